// File: rtl/mem_bus_decoder.sv
// Memory-bus address decoder: maps a single request onto ROM, RAM or the UART registers,
// holds the chosen select for the region's wait states and flags faulting accesses.
module mem_bus_decoder #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] ROM_BASE  = 32'h0,
   parameter logic [ADDR_W-1:0] ROM_SIZE  = 32'h400,
   parameter logic [ADDR_W-1:0] RAM_BASE  = 32'h400,
   parameter logic [ADDR_W-1:0] RAM_SIZE  = 32'h100,
   parameter logic [ADDR_W-1:0] UART_DATA = 32'h500,
   parameter logic [ADDR_W-1:0] UART_STAT = 32'h504,
   parameter int unsigned       ROM_WAIT  = 0,
   parameter int unsigned       RAM_WAIT  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] Addr,
   output logic              ready,
   output logic              bus_err,
   output logic              busy,
   output logic              ROM_CS,
   output logic              RAM_CS,
   output logic              RAM_WE,
   output logic              CE_UART,
   output logic              UART_WR,
   output logic              UART_RD,
   output logic              CE_SR,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {StIdle, StAccess, StErr} state_e;

   // Region bounds carry one extra bit so BASE+SIZE-1 at the top of the map cannot wrap.
   localparam logic [ADDR_W:0] One   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] RomLo = {1'b0, ROM_BASE};
   localparam logic [ADDR_W:0] RomHi = {1'b0, ROM_BASE} + {1'b0, ROM_SIZE} - One;
   localparam logic [ADDR_W:0] RamLo = {1'b0, RAM_BASE};
   localparam logic [ADDR_W:0] RamHi = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE} - One;
   localparam logic [3:0]      RomWt = 4'(ROM_WAIT);
   localparam logic [3:0]      RamWt = 4'(RAM_WAIT);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        bus_err_q, bus_err_d;
   logic        busy_q, busy_d;
   logic        rom_cs_q, rom_cs_d;
   logic        ram_cs_q, ram_cs_d;
   logic        ram_we_q, ram_we_d;
   logic        ce_uart_q, ce_uart_d;
   logic        uart_wr_q, uart_wr_d;
   logic        uart_rd_q, uart_rd_d;
   logic        ce_sr_q, ce_sr_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   logic [ADDR_W:0] addr_x;
   logic            in_rom, in_ram, in_ud, in_us;
   logic            hit_rom, hit_ram, hit_ud, hit_us;
   logic            fault;

   // Region decode, resolved by priority ROM > RAM > UART_DATA > UART_STAT.
   always_comb begin
      addr_x  = {1'b0, Addr};
      in_rom  = (addr_x >= RomLo) && (addr_x <= RomHi);
      in_ram  = (addr_x >= RamLo) && (addr_x <= RamHi);
      in_ud   = (Addr == UART_DATA);
      in_us   = (Addr == UART_STAT);
      hit_rom = in_rom;
      hit_ram = in_ram && !in_rom;
      hit_ud  = in_ud && !in_rom && !in_ram;
      hit_us  = in_us && !in_rom && !in_ram && !in_ud;
      fault   = !(hit_rom || hit_ram || hit_ud || hit_us)
                || (Addr[1:0] != 2'b00)
                || (hit_rom && MemWrite)
                || (hit_us && MemWrite);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      bus_err_d = 1'b0;
      rom_cs_d  = rom_cs_q;
      ram_cs_d  = ram_cs_q;
      ram_we_d  = ram_we_q;
      ce_uart_d = ce_uart_q;
      uart_wr_d = uart_wr_q;
      uart_rd_d = uart_rd_q;
      ce_sr_d   = ce_sr_q;
      err_cnt_d = err_cnt_q;

      unique case (state_q)
         StIdle: begin
            rom_cs_d  = 1'b0;
            ram_cs_d  = 1'b0;
            ram_we_d  = 1'b0;
            ce_uart_d = 1'b0;
            uart_wr_d = 1'b0;
            uart_rd_d = 1'b0;
            ce_sr_d   = 1'b0;
            if (req) begin
               if (fault) begin
                  state_d   = StErr;
                  ready_d   = 1'b1;
                  bus_err_d = 1'b1;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end else begin
                  // Selects latched here stay frozen until the access drains.
                  state_d   = StAccess;
                  rom_cs_d  = hit_rom;
                  ram_cs_d  = hit_ram;
                  ram_we_d  = hit_ram && MemWrite;
                  ce_uart_d = hit_ud;
                  ce_sr_d   = hit_us;
                  uart_wr_d = hit_ud && MemWrite;
                  uart_rd_d = (hit_ud || hit_us) && !MemWrite;
                  if (hit_rom) begin
                     cnt_d = RomWt;
                  end else if (hit_ram) begin
                     cnt_d = RamWt;
                  end else begin
                     cnt_d = 4'd0;
                  end
                  ready_d = (cnt_d == 4'd0);
               end
            end
         end
         StAccess: begin
            if (cnt_q == 4'd0) begin
               state_d   = StIdle;
               rom_cs_d  = 1'b0;
               ram_cs_d  = 1'b0;
               ram_we_d  = 1'b0;
               ce_uart_d = 1'b0;
               uart_wr_d = 1'b0;
               uart_rd_d = 1'b0;
               ce_sr_d   = 1'b0;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               ready_d = (cnt_q == 4'd1);
            end
         end
         StErr: begin
            state_d = StIdle;
         end
         default: begin
            state_d   = StIdle;
            rom_cs_d  = 1'b0;
            ram_cs_d  = 1'b0;
            ram_we_d  = 1'b0;
            ce_uart_d = 1'b0;
            uart_wr_d = 1'b0;
            uart_rd_d = 1'b0;
            ce_sr_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         ready_q   <= 1'b0;
         bus_err_q <= 1'b0;
         busy_q    <= 1'b0;
         rom_cs_q  <= 1'b0;
         ram_cs_q  <= 1'b0;
         ram_we_q  <= 1'b0;
         ce_uart_q <= 1'b0;
         uart_wr_q <= 1'b0;
         uart_rd_q <= 1'b0;
         ce_sr_q   <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         bus_err_q <= bus_err_d;
         busy_q    <= busy_d;
         rom_cs_q  <= rom_cs_d;
         ram_cs_q  <= ram_cs_d;
         ram_we_q  <= ram_we_d;
         ce_uart_q <= ce_uart_d;
         uart_wr_q <= uart_wr_d;
         uart_rd_q <= uart_rd_d;
         ce_sr_q   <= ce_sr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign ready     = ready_q;
   assign bus_err   = bus_err_q;
   assign busy      = busy_q;
   assign ROM_CS    = rom_cs_q;
   assign RAM_CS    = ram_cs_q;
   assign RAM_WE    = ram_we_q;
   assign CE_UART   = ce_uart_q;
   assign UART_WR   = uart_wr_q;
   assign UART_RD   = uart_rd_q;
   assign CE_SR     = ce_sr_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Bench for mem_bus_decoder: directed scenarios plus random accesses checked cycle by cycle
// against a reference model of the address map, wait states and fault counter.
module tb_mem_bus_decoder;

   localparam longint RomBase = 64'h0;
   localparam longint RomSize = 64'h400;
   localparam longint RamBase = 64'h400;
   localparam longint RamSize = 64'h100;
   localparam longint UartData = 64'h500;
   localparam longint UartStat = 64'h504;
   localparam int     RomWait = 0;
   localparam int     RamWait = 2;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        MemWrite;
   logic [31:0] Addr;
   logic        ready, bus_err, busy;
   logic        ROM_CS, RAM_CS, RAM_WE, CE_UART, UART_WR, UART_RD, CE_SR;
   logic [7:0]  err_count;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int err_m     = 0;

   mem_bus_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .MemWrite  (MemWrite),
      .Addr      (Addr),
      .ready     (ready),
      .bus_err   (bus_err),
      .busy      (busy),
      .ROM_CS    (ROM_CS),
      .RAM_CS    (RAM_CS),
      .RAM_WE    (RAM_WE),
      .CE_UART   (CE_UART),
      .UART_WR   (UART_WR),
      .UART_RD   (UART_RD),
      .CE_SR     (CE_SR),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ready, bus_err, busy, ROM_CS, RAM_CS, RAM_WE, CE_UART, UART_WR, UART_RD, CE_SR, err_count}
   function automatic logic [17:0] observe();
      return {ready, bus_err, busy, ROM_CS, RAM_CS, RAM_WE, CE_UART, UART_WR, UART_RD, CE_SR,
              err_count};
   endfunction

   task automatic chk(input string tag, input logic [17:0] exp);
      logic [17:0] obs;
      obs = observe();
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Address map rules: which select pattern an access should produce, and its wait count.
   task automatic model(input logic [31:0] a, input logic w, output logic flt,
                        output logic [6:0] sel, output int nw);
      longint ua;
      logic rom, ram, ud, us;
      ua  = longint'(a);
      rom = (ua >= RomBase) && (ua < RomBase + RomSize);
      ram = !rom && (ua >= RamBase) && (ua < RamBase + RamSize);
      ud  = !rom && !ram && (ua == UartData);
      us  = !rom && !ram && !ud && (ua == UartStat);
      flt = !(rom || ram || ud || us) || (a[1:0] != 2'b00) || (rom && w) || (us && w);
      sel = flt ? 7'b0 : {rom, ram, ram && w, ud, ud && w, (ud || us) && !w, us};
      nw  = rom ? RomWait : (ram ? RamWait : 0);
   endtask

   task automatic run_txn(input string tag, input logic [31:0] a, input logic w);
      logic       flt;
      logic [6:0] sel;
      int         nw, n;
      model(a, w, flt, sel, nw);
      @(negedge clk);
      req      = 1'b1;
      Addr     = a;
      MemWrite = w;
      if (flt) begin
         err_m = (err_m == 255) ? 255 : err_m + 1;
         n     = 1;
      end else begin
         n = nw + 1;
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            // Inputs scrambled after acceptance must not disturb the access.
            req      = 1'b0;
            Addr     = $urandom;
            MemWrite = ~w;
         end
         if (flt) chk({tag, "_err"}, {3'b111, 7'b0, 8'(err_m)});
         else     chk({tag, "_acc"}, {(i == n - 1), 1'b0, 1'b1, sel, 8'(err_m)});
      end
      @(negedge clk);
      chk({tag, "_idle"}, {10'b0, 8'(err_m)});
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: return 32'h0;
         1: return 32'h3FC;
         2: return 32'h400;
         3: return 32'h4FC;
         4: return 32'h500;
         5: return 32'h504;
         6: return 32'hFFFF_FFFC;
         7: return {22'h0, r[9:0]};
         8: return 32'h400 + {24'h0, r[7:0]};
         default: return r;
      endcase
   endfunction

   initial begin
      rst_n    = 1'b1;
      req      = 1'b0;
      MemWrite = 1'b0;
      Addr     = 32'h0;
      #1 rst_n = 1'b0;
      #2 chk("reset_state", 18'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_reset_idle", 18'h0);

      run_txn("rom_read_3fc", 32'h3FC, 1'b0);
      run_txn("ram_write_400", 32'h400, 1'b1);
      run_txn("uart_data_wr", 32'h500, 1'b1);
      run_txn("uart_data_rd", 32'h500, 1'b0);
      run_txn("uart_stat_rd", 32'h504, 1'b0);
      run_txn("fault_600", 32'h600, 1'b0);
      run_txn("fault_402", 32'h402, 1'b0);
      run_txn("fault_rom_wr", 32'h10, 1'b1);
      run_txn("fault_stat_wr", 32'h504, 1'b1);
      run_txn("ram_read_4fc", 32'h4FC, 1'b0);
      run_txn("fault_top", 32'hFFFF_FFFC, 1'b0);

      for (int k = 0; k < 60; k++) begin
         run_txn("random", rand_addr(), 1'($urandom_range(0, 1)));
      end

      for (int k = 0; k < 256; k++) begin
         run_txn("saturate", 32'h600, 1'b0);
      end
      chk("err_sat", {10'b0, 8'hFF});

      // Reset pulsed in the second cycle of a RAM access.
      @(negedge clk);
      req      = 1'b1;
      Addr     = 32'h404;
      MemWrite = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("rst_ram_c1", {3'b001, 7'b0110000, 8'hFF});
      @(posedge clk);
      #2 rst_n = 1'b0;
      err_m = 0;
      #1 chk("rst_async", 18'h0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_after", 18'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_ready", 18'h0);
      end
      run_txn("ram_after_rst", 32'h408, 1'b0);
      run_txn("rom_after_rst", 32'h0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_bus_decoder.md
MEM_BUS_DECODER -- requirements
Module: mem_bus_decoder

Interface
REQ-001 The block SHALL be parameterised as follows:
- ADDR_W, 32: address width.
- ROM_BASE, 32'h0: first ROM byte address.
- ROM_SIZE, 32'h400: ROM size in bytes.
- RAM_BASE, 32'h400: first RAM byte address.
- RAM_SIZE, 32'h100: RAM size in bytes.
- UART_DATA, 32'h500: UART data register address.
- UART_STAT, 32'h504: UART status register address.
- ROM_WAIT, 0: ROM wait states, range 0..15.
- RAM_WAIT, 2: RAM wait states, range 0..15.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 The ports SHALL be as follows:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req, in, 1: access request.
- MemWrite, in, 1: 1 = write, 0 = read.
- Addr, in, ADDR_W: byte address.
- ready, out, 1: transaction complete.
- bus_err, out, 1: transaction faulted.
- busy, out, 1: transaction in progress.
- ROM_CS, out, 1: ROM select.
- RAM_CS, out, 1: RAM select.
- RAM_WE, out, 1: RAM write enable.
- CE_UART, out, 1: UART data select.
- UART_WR, out, 1: UART write strobe.
- UART_RD, out, 1: UART read strobe.
- CE_SR, out, 1: UART status select.
- err_count, out, 8: saturating fault count.

Function
REQ-004 All outputs SHALL be registered (Moore); none SHALL depend combinationally on req, MemWrite or Addr.
REQ-005 The FSM SHALL have exactly three states: IDLE, ACCESS and ERR.
REQ-006 In IDLE, req is sampled at each rising edge; req is ignored in every other state.
REQ-007 On acceptance, Addr and MemWrite SHALL be latched; later changes to those inputs SHALL have no effect until IDLE is re-entered.
REQ-008 Decode SHALL use priority ROM > RAM > UART_DATA > UART_STAT; region hit is BASE <= Addr <= BASE+SIZE-1, computed at ADDR_W+1 bits so the top address does not wrap.
REQ-009 A fault SHALL be raised for any of the following: no region hit; Addr[1:0] != 0; write to ROM; write to UART_STAT.
- On a fault: next state ERR, with no select or strobe asserted.
REQ-010 For a valid access, the next state SHALL be ACCESS with wait counter loaded as follows:
- ROM: ROM_WAIT.
- RAM: RAM_WAIT.
- UART: 0.
REQ-011 In ACCESS, the select and strobe outputs SHALL be held for exactly WAIT+1 cycles:
- ROM read: ROM_CS.
- RAM access: RAM_CS, with RAM_WE = latched MemWrite.
- UART_DATA write: CE_UART and UART_WR.
- UART_DATA read: CE_UART and UART_RD.
- UART_STAT read: CE_SR and UART_RD.
REQ-012 ready SHALL be 1 only in the final ACCESS cycle (counter == 0); the state then returns to IDLE.
REQ-013 ERR SHALL last exactly one cycle with ready=1 and bus_err=1, then return to IDLE.
REQ-014 err_count SHALL increment on entry to ERR and saturate at 8'hFF.
REQ-015 busy SHALL be 1 whenever state != IDLE.
REQ-016 Latency: a request accepted at edge k SHALL give ready in cycle k+1+WAIT.
REQ-017 At least one IDLE cycle SHALL separate consecutive transactions.
REQ-018 At most one of ROM_CS, RAM_CS, CE_UART and CE_SR SHALL be 1 in any cycle.
REQ-019 UART_WR and UART_RD SHALL never both be 1 in the same cycle.

Reset
REQ-020 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- all selects, strobes, ready, bus_err and busy to 0;
- err_count to 0.
REQ-021 Reset asserted mid-ACCESS SHALL abort the transaction; no ready is produced for it.
REQ-022 After rst_n deasserts, the first request SHALL be accepted at the first rising edge with req=1.

Verification
REQ-023 The bench SHALL cover the following directed scenarios (default parameters):
- ROM read, Addr=0x3FC: ROM_CS=1 for 1 cycle, with ready=1 in that same cycle; bus_err=0.
- RAM write, Addr=0x400, MemWrite=1: RAM_CS=RAM_WE=1 for 3 cycles; ready=1 only in the 3rd. Addr changed mid-access has no effect.
- UART_DATA write, then read, then UART_STAT read: first CE_UART+UART_WR, then CE_UART+UART_RD, then CE_SR+UART_RD; each 1 cycle with ready.
- Faults on Addr=0x600, then 0x402, then a write to 0x10: each gives 1 cycle of ready=bus_err=1 with no selects; err_count 0 -> 3.
- 256 faulting accesses: err_count holds at 0xFF.
- rst_n pulsed low in the 2nd cycle of a RAM access: all outputs 0 at once, no ready; the next request completes normally.
